alu_cmd_ctrl: RTL and testbench
===============================

// Module: alu_cmd_ctrl
// PURPOSE
// - Command-side master of the ALU. It takes byte frames from the UART RX side, drives the ALU operand,
//   function and enable inputs, and samples the ALU result/valid. It returns the 16-bit result to the
//   UART TX side as two bytes, or returns one error byte.
// - Sits between the RX byte stream and TX byte stream in the system controller path.
// PARAMETERS
// - DATA_WIDTH   8     operand width; also the byte width on RX/TX
// - FUN_WIDTH    4     ALU function code width
// - ALU_LAT      2     cycles alu_en is held per operation (covers registered multiplier/divider)
// - OP_CMD_AB    8'hCC opcode: operands + function follow (A, B, FUN bytes)
// - OP_CMD_FUN   8'hDD opcode: function only; reuses the stored A/B
// - ERR_CODE     8'hEE byte sent when the ALU reports an invalid result
// PORTS
// - CLK            in   1    clock
// - RST            in   1    reset, asynchronous, active-low
// - rx_data        in   8    received byte
// - rx_valid       in   1    1-cycle pulse; rx_data is valid this cycle
// - alu_a          out  8    ALU operand A (stored register)
// - alu_b          out  8    ALU operand B (stored register)
// - alu_fun        out  4    ALU function code
// - alu_en         out  1    ALU enable
// - alu_out        in   16   ALU result
// - alu_out_valid  in   1    ALU result valid; 0 after enable means error (e.g. divide by zero)
// - tx_data        out  8    byte to transmit
// - tx_valid       out  1    tx_data valid; held until accepted
// - tx_ready       in   1    TX can accept; a byte transfers on a cycle with tx_valid & tx_ready
// - cmd_error      out  1    1-cycle pulse: bad opcode, bad FUN byte, or byte dropped while busy
// - busy           out  1    high in every state except IDLE
// BEHAVIOUR
// - Reset: all outputs and stored alu_a, alu_b, alu_fun, result are 0; FSM goes to IDLE.
//   Reset is asynchronous, so it aborts any operation in flight, including EXEC and SEND.
// - FSM states: IDLE, GET_A, GET_B, GET_FUN, EXEC, CHECK, SEND_LO, SEND_HI, SEND_ERR.
// - IDLE: on rx_valid:
//     - rx_data == OP_CMD_AB  -> GET_A
//     - rx_data == OP_CMD_FUN -> GET_FUN
//     - any other byte        -> pulse cmd_error, stay in IDLE
// - GET_A: on rx_valid, latch the byte into alu_a -> GET_B.
// - GET_B: on rx_valid, latch the byte into alu_b -> GET_FUN.
// - GET_FUN: on rx_valid:
//     - rx_data[7:4] == 0 -> latch rx_data[3:0] into alu_fun -> EXEC
//     - otherwise         -> pulse cmd_error -> IDLE; alu_fun is unchanged
// - There is no inter-byte timeout; GET_* states wait indefinitely.
// - EXEC: alu_en = 1 for exactly ALU_LAT consecutive cycles; alu_a, alu_b, alu_fun stay stable.
// - CHECK: the single cycle after the last alu_en cycle; alu_en = 0.
//     - alu_out_valid == 1 -> capture alu_out into the result register -> SEND_LO
//     - alu_out_valid == 0 -> SEND_ERR
// - SEND_LO: tx_data = result[7:0], tx_valid = 1; on tx_ready -> SEND_HI.
// - SEND_HI: tx_data = result[15:8], tx_valid = 1; on tx_ready -> IDLE. tx_valid drops next cycle.
// - SEND_ERR: tx_data = ERR_CODE, tx_valid = 1; on tx_ready -> IDLE.
// - Transfer rules: tx_data does not change while tx_valid = 1 and tx_ready = 0.
//   tx_valid is never deasserted before acceptance. A new frame is processed only after return to IDLE.
// - rx_valid in EXEC, CHECK or SEND_*: the byte is dropped and cmd_error pulses; the FSM is unaffected.
// - Exactly one cmd_error pulse per offending byte.
// - Arithmetic/width: no arithmetic is done here; the result is passed through unmodified, LSB byte first.
// - Back-to-back: with tx_ready tied to 1, an OP_CMD_AB frame completes
//   (frame byte 4 -> SEND_HI accepted) in ALU_LAT + 3 cycles after the last rx_valid.
// TESTING
// - CC,05,03,00 -> alu_a=05, alu_b=03, alu_fun=0, alu_en high 2 cycles; TX bytes 08 then 00.
// - CC,10,00,03 with the ALU returning alu_out_valid=0 in CHECK -> single TX byte EE; no further bytes.
// - After the first test, send DD,02 with the ALU returning 000F -> operands 05/03 reused; TX 0F, 00.
// - Send 55; later send CC,01,02,1A -> cmd_error pulses once per bad byte; no alu_en; FSM back in IDLE.
// - tx_ready held low for 10 cycles in SEND_LO -> tx_valid=1 and tx_data stable throughout;
//   extra rx bytes sent during that time each give a cmd_error pulse.
// - Drop RST low during EXEC -> alu_en, tx_valid, busy = 0 immediately; alu_a, alu_b = 0;
//   after release, the next frame is processed normally.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU master: parses RX command frames, sequences the ALU enable window,
// and returns the 16-bit result (LSB first) or a single error byte on the TX side.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FUN_WIDTH  = 4,
    parameter int                    ALU_LAT    = 2,
    parameter logic [DATA_WIDTH-1:0] OP_CMD_AB  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] OP_CMD_FUN = 8'hDD,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE   = 8'hEE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [FUN_WIDTH-1:0]    alu_fun,
    output logic                    alu_en,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_valid,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    cmd_error,
    output logic                    busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_A    = 4'd1,
        GET_B    = 4'd2,
        GET_FUN  = 4'd3,
        EXEC     = 4'd4,
        CHECK    = 4'd5,
        SEND_LO  = 4'd6,
        SEND_HI  = 4'd7,
        SEND_ERR = 4'd8
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic [DATA_WIDTH-1:0]   alu_a_r;
    logic [DATA_WIDTH-1:0]   alu_b_r;
    logic [FUN_WIDTH-1:0]    alu_fun_r;
    logic [2*DATA_WIDTH-1:0] result_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic [DATA_WIDTH-1:0]   tx_data_next_s;
    logic                    tx_valid_r;
    logic                    alu_en_r;
    logic                    busy_r;
    logic                    cmd_error_r;
    logic                    lat_a_s;
    logic                    lat_b_s;
    logic                    lat_fun_s;
    logic                    cap_res_s;
    logic                    err_s;
    logic                    fun_ok_s;
    logic                    is_send_s;

    // A function byte is legal only when every bit above the function field is clear.
    assign fun_ok_s = (rx_data[DATA_WIDTH-1:FUN_WIDTH] == {(DATA_WIDTH-FUN_WIDTH){1'b0}});

    // Next-state decode, operand latch strobes and cmd_error request.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        lat_a_s      = 1'b0;
        lat_b_s      = 1'b0;
        lat_fun_s    = 1'b0;
        cap_res_s    = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_CMD_AB) begin
                        next_state_s = GET_A;
                    end else if (rx_data == OP_CMD_FUN) begin
                        next_state_s = GET_FUN;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            GET_A: begin
                if (rx_valid) begin
                    lat_a_s      = 1'b1;
                    next_state_s = GET_B;
                end else begin
                    next_state_s = GET_A;
                end
            end
            GET_B: begin
                if (rx_valid) begin
                    lat_b_s      = 1'b1;
                    next_state_s = GET_FUN;
                end else begin
                    next_state_s = GET_B;
                end
            end
            GET_FUN: begin
                if (rx_valid) begin
                    if (fun_ok_s) begin
                        lat_fun_s    = 1'b1;
                        cnt_next_s   = {CNT_W{1'b0}};
                        next_state_s = EXEC;
                    end else begin
                        err_s        = 1'b1;
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = GET_FUN;
                end
            end
            EXEC: begin
                err_s = rx_valid;
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    next_state_s = CHECK;
                end else begin
                    cnt_next_s   = cnt_r + 1'b1;
                end
            end
            CHECK: begin
                err_s = rx_valid;
                if (alu_out_valid) begin
                    cap_res_s    = 1'b1;
                    next_state_s = SEND_LO;
                end else begin
                    next_state_s = SEND_ERR;
                end
            end
            SEND_LO: begin
                err_s = rx_valid;
                if (tx_ready) begin
                    next_state_s = SEND_HI;
                end else begin
                    next_state_s = SEND_LO;
                end
            end
            SEND_HI: begin
                err_s = rx_valid;
                if (tx_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SEND_HI;
                end
            end
            SEND_ERR: begin
                err_s = rx_valid;
                if (tx_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SEND_ERR;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Byte to present in the next state; on entry to SEND_LO the result register is still loading.
    always_comb begin
        tx_data_next_s = {DATA_WIDTH{1'b0}};
        is_send_s      = 1'b0;
        case (next_state_s)
            SEND_LO: begin
                is_send_s = 1'b1;
                if (cap_res_s) begin
                    tx_data_next_s = alu_out[DATA_WIDTH-1:0];
                end else begin
                    tx_data_next_s = result_r[DATA_WIDTH-1:0];
                end
            end
            SEND_HI: begin
                is_send_s      = 1'b1;
                tx_data_next_s = result_r[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            SEND_ERR: begin
                is_send_s      = 1'b1;
                tx_data_next_s = ERR_CODE;
            end
            default: begin
                is_send_s      = 1'b0;
                tx_data_next_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // State, latency counter and registered status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            alu_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= {DATA_WIDTH{1'b0}};
            cmd_error_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            alu_en_r    <= (next_state_s == EXEC);
            busy_r      <= (next_state_s != IDLE);
            tx_valid_r  <= is_send_s;
            tx_data_r   <= tx_data_next_s;
            cmd_error_r <= err_s;
        end
    end

    // Operand, function and result storage; values persist across frames for OP_CMD_FUN reuse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_a_r   <= {DATA_WIDTH{1'b0}};
            alu_b_r   <= {DATA_WIDTH{1'b0}};
            alu_fun_r <= {FUN_WIDTH{1'b0}};
            result_r  <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            if (lat_a_s) begin
                alu_a_r <= rx_data;
            end
            if (lat_b_s) begin
                alu_b_r <= rx_data;
            end
            if (lat_fun_s) begin
                alu_fun_r <= rx_data[FUN_WIDTH-1:0];
            end
            if (cap_res_s) begin
                result_r <= alu_out;
            end
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_fun   = alu_fun_r;
    assign alu_en    = alu_en_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign cmd_error = cmd_error_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed vector table, hand sequences and
// randomized frames checked against a frame-level reference model with an ALU stand-in.
module tb_alu_cmd_ctrl;

    localparam int ALU_LAT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cmd_error;
    logic        busy;

    logic ready_ctl = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_bit = 1'b1;
    logic inj_en = 1'b0;
    assign tx_ready = rand_ready ? rnd_bit : ready_ctl;

    alu_cmd_ctrl #(.ALU_LAT(ALU_LAT)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cmd_error(cmd_error), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: {ok, result}; fun 3 fails on divide by zero, funs 8..F are invalid.
    function automatic logic [16:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] r;
        logic        ok;
        r  = 16'h0000;
        ok = 1'b1;
        case (f)
            4'h0: r = {8'h00, a} + {8'h00, b};
            4'h1: r = {8'h00, a} - {8'h00, b};
            4'h2: r = {8'h00, a} * {8'h00, b};
            4'h3: if (b == 8'h00) ok = 1'b0; else r = {8'h00, a} / {8'h00, b};
            4'h4: r = {8'h00, a & b};
            4'h5: r = {8'h00, a | b};
            4'h6: r = {8'h00, a ^ b};
            4'h7: r = {a, b};
            default: ok = 1'b0;
        endcase
        return {ok, r};
    endfunction

    // ALU stand-in timing: result/valid appear in the cycle after ALU_LAT consecutive enables.
    int en_run;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_run        <= 0;
            alu_out       <= 16'h0000;
            alu_out_valid <= 1'b0;
        end else begin
            en_run <= alu_en ? en_run + 1 : 0;
            if (alu_en && en_run == ALU_LAT - 1) begin
                alu_out       <= alu_ref(alu_a, alu_b, alu_fun) & 17'h0FFFF;
                alu_out_valid <= alu_ref(alu_a, alu_b, alu_fun) >> 16;
            end else begin
                alu_out       <= 16'h0000;
                alu_out_valid <= 1'b0;
            end
        end
    end

    // Random tx_ready source.
    initial forever begin
        @(posedge CLK);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: logs accepted bytes, counts pulses, flags handshake/operand instability.
    logic [7:0]  tx_log [0:4095];
    int          tx_cnt = 0;
    int          err_cnt = 0;
    int          en_cnt = 0;
    int          stab_viol = 0;
    logic        prev_hold = 1'b0;
    logic        prev_en = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [19:0] prev_ops = 20'h00000;
    always @(negedge CLK) begin
        if (tx_valid && tx_ready) begin
            tx_log[tx_cnt] <= tx_data;
            tx_cnt         <= tx_cnt + 1;
        end
        if (cmd_error) err_cnt <= err_cnt + 1;
        if (alu_en) en_cnt <= en_cnt + 1;
        stab_viol <= stab_viol
                   + int'(RST && prev_hold && (!tx_valid || tx_data !== prev_data))
                   + int'(alu_en && prev_en && {alu_a, alu_b, alu_fun} !== prev_ops);
        prev_hold <= tx_valid && !tx_ready;
        prev_data <= tx_data;
        prev_en   <= alu_en;
        prev_ops  <= {alu_a, alu_b, alu_fun};
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    int inj_cnt = 0;
    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy && n < max) begin
            if (inj_en && tx_valid && $urandom_range(0, 3) == 0) begin
                send_byte(8'($urandom_range(0, 255)));
                inj_cnt++;
            end else begin
                @(posedge CLK);
                #1;
            end
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic settle();
        repeat (3) @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          ntx;
        logic [7:0]  t0;
        logic [7:0]  t1;
        int          err;
        int          en;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  f;
    } vec_t;

    vec_t       vt [9];
    logic [7:0] ref_a, ref_b;
    logic [3:0] ref_f;
    logic [7:0] exp_q [$];
    int         exp_err;

    // Frame-level model of a function byte arriving with stored operands ref_a/ref_b.
    task automatic model_fun(input logic [7:0] fb);
        logic [16:0] r;
        if (fb[7:4] != 4'h0) begin
            exp_err++;
        end else begin
            ref_f = fb[3:0];
            r = alu_ref(ref_a, ref_b, ref_f);
            if (r[16]) begin
                exp_q.push_back(r[7:0]);
                exp_q.push_back(r[15:8]);
            end else begin
                exp_q.push_back(8'hEE);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb_tx, eb, enb, n, w, ib, typ, nfr;
        logic [31:0] bv;
        logic [7:0]  fr [4];
        logic [7:0]  bo;

        vt[0] = '{32'hCC050300, 4, 2, 8'h08, 8'h00, 0, 2, 8'h05, 8'h03, 4'h0};
        vt[1] = '{32'hDD020000, 2, 2, 8'h0F, 8'h00, 0, 2, 8'h05, 8'h03, 4'h2};
        vt[2] = '{32'hCC100003, 4, 1, 8'hEE, 8'h00, 0, 2, 8'h10, 8'h00, 4'h3};
        vt[3] = '{32'h55000000, 1, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 4'h3};
        vt[4] = '{32'hCC01021A, 4, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h02, 4'h3};
        vt[5] = '{32'hCCFFFF02, 4, 2, 8'h01, 8'hFE, 0, 2, 8'hFF, 8'hFF, 4'h2};
        vt[6] = '{32'hCC000001, 4, 2, 8'h00, 8'h00, 0, 2, 8'h00, 8'h00, 4'h1};
        vt[7] = '{32'hCC800309, 4, 1, 8'hEE, 8'h00, 0, 2, 8'h80, 8'h03, 4'h9};
        vt[8] = '{32'hDD4F0000, 2, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h03, 4'h9};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_b", int'(alu_b), 0);
        check("rst_alu_fun", int'(alu_fun), 0);
        check("rst_alu_en", int'(alu_en), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_cmd_error", int'(cmd_error), 0);
        check("rst_busy", int'(busy), 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            tb_tx = tx_cnt; eb = err_cnt; enb = en_cnt;
            bv = vt[i].bytes;
            for (int k = 0; k < vt[i].n; k++) send_byte(bv[31-8*k -: 8]);
            wait_idle(100, n);
            settle();
            check($sformatf("v%0d_tx_count", i), tx_cnt - tb_tx, vt[i].ntx);
            if (vt[i].ntx > 0) check($sformatf("v%0d_tx0", i), int'(tx_log[tb_tx]), int'(vt[i].t0));
            if (vt[i].ntx > 1) check($sformatf("v%0d_tx1", i), int'(tx_log[tb_tx+1]), int'(vt[i].t1));
            check($sformatf("v%0d_cmd_error", i), err_cnt - eb, vt[i].err);
            check($sformatf("v%0d_en_cycles", i), en_cnt - enb, vt[i].en);
            check($sformatf("v%0d_alu_a", i), int'(alu_a), int'(vt[i].a));
            check($sformatf("v%0d_alu_b", i), int'(alu_b), int'(vt[i].b));
            check($sformatf("v%0d_alu_fun", i), int'(alu_fun), int'(vt[i].f));
        end

        // Back-to-back latency with tx_ready high: last rx byte to return to IDLE.
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        wait_idle(100, n);
        check("latency_cycles", n, ALU_LAT + 3);
        settle();

        // tx_ready low for 10 cycles in SEND_LO with dropped bytes.
        tb_tx = tx_cnt; eb = err_cnt;
        ready_ctl = 1'b0;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        w = 0;
        while (!tx_valid && w < 20) begin @(posedge CLK); #1; w++; end
        check("hold_wait_tx_valid", int'(tx_valid), 1);
        for (int i = 0; i < 10; i++) begin
            check("hold_tx_valid", int'(tx_valid), 1);
            check("hold_tx_data", int'(tx_data), 8'h46);
            if (i == 2 || i == 5) send_byte(8'hA5);
            else begin @(posedge CLK); #1; end
        end
        ready_ctl = 1'b1;
        wait_idle(100, n);
        settle();
        check("hold_tx_count", tx_cnt - tb_tx, 2);
        check("hold_tx0", int'(tx_log[tb_tx]), 8'h46);
        check("hold_tx1", int'(tx_log[tb_tx+1]), 8'h00);
        check("hold_cmd_error", err_cnt - eb, 2);
        check("hold_stability", stab_viol, 0);

        // Asynchronous reset in EXEC, then a normal frame.
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h09); send_byte(8'h00);
        w = 0;
        while (!alu_en && w < 20) begin @(posedge CLK); #1; w++; end
        check("rst_exec_wait_en", int'(alu_en), 1);
        #2;
        RST = 1'b0;
        #1;
        check("rst_exec_alu_en", int'(alu_en), 0);
        check("rst_exec_tx_valid", int'(tx_valid), 0);
        check("rst_exec_busy", int'(busy), 0);
        check("rst_exec_alu_a", int'(alu_a), 0);
        check("rst_exec_alu_b", int'(alu_b), 0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tb_tx = tx_cnt;
        send_byte(8'hCC); send_byte(8'h02); send_byte(8'h03); send_byte(8'h02);
        wait_idle(100, n);
        settle();
        check("post_rst_tx_count", tx_cnt - tb_tx, 2);
        check("post_rst_tx0", int'(tx_log[tb_tx]), 8'h06);
        check("post_rst_tx1", int'(tx_log[tb_tx+1]), 8'h00);

        // Randomized frames against the reference model.
        ref_a = 8'h02; ref_b = 8'h03; ref_f = 4'h2;
        exp_err = 0;
        tb_tx = tx_cnt; eb = err_cnt; ib = inj_cnt;
        rand_ready = 1'b1;
        inj_en = 1'b1;
        for (int f = 0; f < 150; f++) begin
            wait_idle(200, n);
            typ = $urandom_range(0, 9);
            if (typ <= 4 || typ == 8) begin
                fr[0] = 8'hCC;
                fr[1] = 8'($urandom_range(0, 255));
                fr[2] = (typ == 3) ? 8'h00 : 8'($urandom_range(0, 255));
                fr[3] = (typ == 8) ? {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))}
                                   : {4'h0, 4'($urandom_range(0, 15))};
                nfr = 4;
                ref_a = fr[1];
                ref_b = fr[2];
                model_fun(fr[3]);
            end else if (typ == 5 || typ == 6 || typ == 9) begin
                fr[0] = 8'hDD;
                fr[1] = (typ == 9) ? {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))}
                                   : {4'h0, 4'($urandom_range(0, 7))};
                nfr = 2;
                model_fun(fr[1]);
            end else begin
                do bo = 8'($urandom_range(0, 255)); while (bo == 8'hCC || bo == 8'hDD);
                fr[0] = bo;
                nfr = 1;
                exp_err++;
            end
            for (int k = 0; k < nfr; k++) begin
                send_byte(fr[k]);
                if (k < nfr - 1) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            end
        end
        wait_idle(200, n);
        inj_en = 1'b0;
        rand_ready = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("rand_tx_count", tx_cnt - tb_tx, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_cnt - tb_tx; i++)
            check($sformatf("rand_tx_byte%0d", i), int'(tx_log[tb_tx+i]), int'(exp_q[i]));
        check("rand_cmd_error", err_cnt - eb, exp_err + (inj_cnt - ib));
        check("rand_stability", stab_viol, 0);
        check("rand_alu_a", int'(alu_a), int'(ref_a));
        check("rand_alu_b", int'(alu_b), int'(ref_b));
        check("rand_alu_fun", int'(alu_fun), int'(ref_f));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
